ws2811_pixel_serializer: RTL and testbench
==========================================

// Module: ws2811_pixel_serializer
// PURPOSE
//  Upstream neighbour of the WS2811 encoder. Accepts 24-bit GRB pixel words over a valid/ready handshake.
//  Drives each bit MSB-first as the encoder's unmodulated data input (serData) plus a data strobe (serClk),
//  one bit per BIT_CYC masterClk cycles. Inserts the WS2811 latch/reset gap after each frame.
//  Sits between the satellite pixel buffer/register file and the encoder.
// PARAMETERS
//  BIT_CYC    50    masterClk cycles per bit slot (1.25 us @ 40 MHz); must exceed the encoder's T1H_CYC+2
//  LATCH_CYC  2400  masterClk cycles of idle low strobe closing a frame (60 us @ 40 MHz, >50 us spec)
//  PIX_BITS   24    bits per pixel word
// PORTS
//  masterClk    in   1   system clock; all logic on posedge
//  rst          in   1   asynchronous, active-high reset
//  pixData      in   24  pixel word, G[23:16] R[15:8] B[7:0]; bit 23 sent first
//  pixValid     in   1   pixData/pixLast valid
//  pixLast      in   1   qualifies pixData as the final pixel of the frame
//  pixReady     out  1   holding register empty; transfer when pixValid && pixReady
//  serData      out  1   bit to encoder dataIn
//  serClk       out  1   strobe to encoder dataClk; its rising edge starts a bit
//  busy         out  1   high in LOAD/SHIFT/LATCH
//  underrun     out  1   sticky: frame ended without pixLast; cleared on next accepted pixel
//  frameCnt     out  16  completed frames (stats)
//  underrunCnt  out  8   underrun events, saturating (stats)
// BEHAVIOUR
//  Reset (async): serData=0, serClk=0, pixReady=0, busy=1, underrun=0, counters=0.
//   State=LATCH with latch count 0, so the first bit starts >= LATCH_CYC cycles after reset release.
//   A reset mid-bit truncates the pulse; the enforced gap resynchronises the LED chain.
//  Storage: 24-bit shift register plus a one-entry holding register (hold, holdLast, holdValid).
//   pixReady = !holdValid registered, deasserted the cycle after a transfer.
//  States:
//   IDLE:  pixReady=1; on holdValid -> LOAD.
//   LOAD:  move hold into the shift register; clear holdValid; bitIdx=0, cyc=0 -> SHIFT.
//   SHIFT: cyc 0..BIT_CYC-1 per bit.
//    cyc==0: serData <= shreg[23].
//    cyc==1..BIT_CYC/2: serClk=1 (rises one cycle after serData settles).
//    cyc>BIT_CYC/2: serClk=0. serData holds for the whole slot.
//    At cyc==BIT_CYC-1: shift left, bitIdx++.
//    At end of bit PIX_BITS-1:
//     - holdValid -> load next pixel directly; no gap, bit slots stay contiguous.
//     - else curLast -> LATCH; frameCnt++.
//     - else -> LATCH; underrun=1; underrunCnt++ (saturate at 255).
//   LATCH: serClk=0, serData=0 for LATCH_CYC cycles.
//    Then -> LOAD if holdValid, else IDLE, with busy=0.
//  Transfers are accepted in any state while holdValid==0, including during LATCH.
//  Counters wrap (frameCnt) or saturate (underrunCnt). cyc/bitIdx widths come from $clog2 of the parameters.
// CONFIGURATION
//  WS2811_SER_STATS_EN
//   defined:   frameCnt/underrunCnt count as above.
//   undefined: both ports tied to 0, counter logic removed; the underrun flag is still present.
// STRUCTURE
//  Shared constants (default BIT_CYC/LATCH_CYC derived from master clock frequency, PIX_BITS, state encodings)
//   live in genericIOSateliteEnv.v alongside the encoder's T0H/T1H cycle defines.
//  One sub-module: ws2811_bit_timer.
//   Owns the cyc counter and emits bitStart/strobeEnd/bitEnd pulses.
//   Reused for LATCH counting via a load value.
// TESTING
//  1. Reset release, pixel 0xA50000 pixLast=1 at t0.
//     -> first serClk rise >= 2400 cycles after reset release.
//     -> serData pattern 1010_0101 then 16 zeros; serClk period 50, high 25; frameCnt=1.
//  2. Three pixels streamed back-to-back, last flagged.
//     -> 72 contiguous bit slots, no gap between pixels.
//     -> pixReady low for exactly 1 cycle after each transfer when hold is consumed promptly.
//  3. Single pixel with pixLast=0, no follow-up.
//     -> after bit 23: underrun=1, underrunCnt=1, 2400-cycle LATCH, then IDLE.
//     -> next accepted pixel clears underrun.
//  4. Reset asserted at bit 10 cyc 12.
//     -> serClk/serData low asynchronously.
//     -> no strobe for 2400 cycles after release; shift and holding contents discarded.
//  5. Pixel offered during LATCH.
//     -> accepted immediately.
//     -> first bit starts at LATCH_CYC+2 cycles after LATCH entry (LOAD, then cyc 1), never earlier.
//  6. Build without WS2811_SER_STATS_EN, rerun 1 and 3.
//     -> frameCnt and underrunCnt stay 0; serial waveform identical.

Source files
------------

// File: rtl/ws2811_pixel_serializer_pkg.sv
// ws2811_pixel_serializer_pkg: timing defaults derived from the master
// clock, pixel width and FSM state encoding for the pixel serializer.
package ws2811_pixel_serializer_pkg;

  localparam int unsigned MCLK_KHZ = 40_000;
  localparam int unsigned BIT_NS   = 1_250;
  localparam int unsigned LATCH_US = 60;

  localparam int unsigned DEF_BIT_CYC   = MCLK_KHZ * BIT_NS / 1_000_000;
  localparam int unsigned DEF_LATCH_CYC = MCLK_KHZ * LATCH_US / 1_000;
  localparam int unsigned DEF_PIX_BITS  = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH
  } ser_state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ws2811_bit_timer.sv
// ws2811_bit_timer: slot counter for the serializer. Counts 0..last and
// flags slot start, strobe end and slot end; reloaded for the latch gap.
module ws2811_bit_timer #(
  parameter int unsigned CW       = 12,
  parameter int unsigned HALF     = 25,
  parameter int unsigned RST_LAST = 2399
) (
  input  logic          masterClk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [CW-1:0] i_last,
  output logic          o_bitStart,
  output logic          o_strobeEnd,
  output logic          o_bitEnd
);

  logic [CW-1:0] r_cyc;
  logic [CW-1:0] r_last;

  // Slot counter: restarts on i_start, wraps to 0 after r_last.
  always_ff @(posedge masterClk or posedge rst) begin
    if (rst) begin
      r_cyc  <= '0;
      r_last <= CW'(RST_LAST);
    end else if (i_start) begin
      r_cyc  <= '0;
      r_last <= i_last;
    end else if (o_bitEnd) begin
      r_cyc <= '0;
    end else begin
      r_cyc <= r_cyc + CW'(1);
    end
  end

  assign o_bitStart  = (r_cyc == '0);
  assign o_strobeEnd = (r_cyc == CW'(HALF));
  assign o_bitEnd    = (r_cyc == r_last);

endmodule

// File: rtl/ws2811_pixel_serializer.sv
// ws2811_pixel_serializer: GRB pixel words to serData/serClk bit slots
// with a latch gap per frame. Stats counters need WS2811_SER_STATS_EN.
module ws2811_pixel_serializer
  import ws2811_pixel_serializer_pkg::*;
#(
  parameter int unsigned BIT_CYC   = DEF_BIT_CYC,
  parameter int unsigned LATCH_CYC = DEF_LATCH_CYC,
  parameter int unsigned PIX_BITS  = DEF_PIX_BITS
) (
  input  logic                masterClk,
  input  logic                rst,
  input  logic [PIX_BITS-1:0] pixData,
  input  logic                pixValid,
  input  logic                pixLast,
  output logic                pixReady,
  output logic                serData,
  output logic                serClk,
  output logic                busy,
  output logic                underrun,
  output logic [15:0]         frameCnt,
  output logic [7:0]          underrunCnt
);

  localparam int unsigned MAXC = (LATCH_CYC > BIT_CYC) ? LATCH_CYC : BIT_CYC;
  localparam int unsigned CW   = cnt_w(MAXC);
  localparam int unsigned BW   = cnt_w(PIX_BITS);
  localparam logic [CW-1:0] C_BIT_LAST   = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] C_LATCH_LAST = CW'(LATCH_CYC - 1);
  localparam logic [BW-1:0] C_LAST_BIT   = BW'(PIX_BITS - 1);

  ser_state_e          r_state;
  logic [PIX_BITS-1:0] r_shreg;
  logic [PIX_BITS-1:0] r_hold;
  logic [BW-1:0]       r_bitIdx;
  logic                r_curLast;
  logic                r_holdLast;
  logic                r_holdValid;
  logic                r_pixReady;
  logic                r_serData;
  logic                r_serClk;
  logic                r_busy;
  logic                r_underrun;

  logic          w_bitStart;
  logic          w_strobeEnd;
  logic          w_bitEnd;
  logic          w_inShift;
  logic          w_pixEnd;
  logic          w_chain;
  logic          w_urEvent;
  logic          w_xfer;
  logic          w_consume;
  logic          w_holdNext;
  logic          w_tStart;
  logic [CW-1:0] w_tLast;

  assign w_inShift  = (r_state == ST_SHIFT);
  assign w_pixEnd   = w_inShift && w_bitEnd && (r_bitIdx == C_LAST_BIT);
  assign w_chain    = w_pixEnd && r_holdValid;
  assign w_urEvent  = w_pixEnd && !r_holdValid && !r_curLast;
  assign w_xfer     = pixValid && r_pixReady;
  assign w_consume  = (r_state == ST_LOAD) || w_chain;
  assign w_holdNext = r_holdValid ? !w_consume : w_xfer;
  assign w_tStart   = (r_state == ST_LOAD) || (w_pixEnd && !r_holdValid);
  assign w_tLast    = (r_state == ST_LOAD) ? C_BIT_LAST : C_LATCH_LAST;

  ws2811_bit_timer #(
    .CW       (CW),
    .HALF     (BIT_CYC / 2),
    .RST_LAST (LATCH_CYC - 1)
  ) u_timer (
    .masterClk   (masterClk),
    .rst         (rst),
    .i_start     (w_tStart),
    .i_last      (w_tLast),
    .o_bitStart  (w_bitStart),
    .o_strobeEnd (w_strobeEnd),
    .o_bitEnd    (w_bitEnd)
  );

  // Holding register, shift register and serial FSM with registered outputs.
  always_ff @(posedge masterClk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_LATCH;
      r_shreg     <= '0;
      r_hold      <= '0;
      r_bitIdx    <= '0;
      r_curLast   <= 1'b0;
      r_holdLast  <= 1'b0;
      r_holdValid <= 1'b0;
      r_pixReady  <= 1'b0;
      r_serData   <= 1'b0;
      r_serClk    <= 1'b0;
      r_busy      <= 1'b1;
      r_underrun  <= 1'b0;
    end else begin
      r_holdValid <= w_holdNext;
      r_pixReady  <= !w_holdNext;
      if (w_xfer) begin
        r_hold     <= pixData;
        r_holdLast <= pixLast;
        r_underrun <= 1'b0;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (r_holdValid) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_shreg   <= r_hold;
          r_curLast <= r_holdLast;
          r_serData <= r_hold[PIX_BITS-1];
          r_bitIdx  <= '0;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_bitStart) r_serClk <= 1'b1;
          if (w_strobeEnd) r_serClk <= 1'b0;
          if (w_bitEnd) begin
            if (r_bitIdx != C_LAST_BIT) begin
              r_shreg   <= r_shreg << 1;
              r_serData <= r_shreg[PIX_BITS-2];
              r_bitIdx  <= r_bitIdx + BW'(1);
            end else if (r_holdValid) begin
              r_shreg   <= r_hold;
              r_curLast <= r_holdLast;
              r_serData <= r_hold[PIX_BITS-1];
              r_bitIdx  <= '0;
            end else begin
              r_serData <= 1'b0;
              r_state   <= ST_LATCH;
              if (w_urEvent) r_underrun <= 1'b1;
            end
          end
        end
        ST_LATCH: begin
          r_serClk  <= 1'b0;
          r_serData <= 1'b0;
          if (w_bitEnd) begin
            if (r_holdValid) begin
              r_state <= ST_LOAD;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef WS2811_SER_STATS_EN
  logic        w_frameDone;
  logic [15:0] r_frameCnt;
  logic [7:0]  r_urCnt;

  assign w_frameDone = w_pixEnd && !r_holdValid && r_curLast;

  // Completed-frame count wraps; underrun count saturates.
  always_ff @(posedge masterClk or posedge rst) begin
    if (rst) begin
      r_frameCnt <= '0;
      r_urCnt    <= '0;
    end else begin
      if (w_frameDone) r_frameCnt <= r_frameCnt + 16'd1;
      if (w_urEvent && (r_urCnt != 8'hFF)) r_urCnt <= r_urCnt + 8'd1;
    end
  end

  assign frameCnt    = r_frameCnt;
  assign underrunCnt = r_urCnt;
`else
  assign frameCnt    = '0;
  assign underrunCnt = '0;
`endif

  assign pixReady = r_pixReady;
  assign serData  = r_serData;
  assign serClk   = r_serClk;
  assign busy     = r_busy;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_ws2811_pixel_serializer.sv
// tb_ws2811_pixel_serializer: table vectors, corner sequences and random
// frames checked against a bit-level waveform model of the serializer.
module tb_ws2811_pixel_serializer;

  localparam int BIT_CYC   = 50;
  localparam int LATCH_CYC = 2400;
  localparam int HALF      = BIT_CYC / 2;
  localparam int GAP_MIN   = BIT_CYC + LATCH_CYC;
  localparam int LATCH_LEN = BIT_CYC - 1 + LATCH_CYC;

  logic        masterClk = 1'b0;
  logic        rst;
  logic [23:0] pixData;
  logic        pixValid;
  logic        pixLast;
  logic        pixReady;
  logic        serData;
  logic        serClk;
  logic        busy;
  logic        underrun;
  logic [15:0] frameCnt;
  logic [7:0]  underrunCnt;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int glitches = 0;
  int mFrames = 0;
  int mUr = 0;

  int riseT[$];
  bit bits[$];
  int hiW[$];
  bit expBits[$];
  bit gapBefore[$];

  typedef struct {
    logic [23:0] data;
    logic        last;
    logic        expUr;
    logic [23:0] expWord;
  } vec_t;

  vec_t tbl[4];

  ws2811_pixel_serializer dut (
    .masterClk   (masterClk),
    .rst         (rst),
    .pixData     (pixData),
    .pixValid    (pixValid),
    .pixLast     (pixLast),
    .pixReady    (pixReady),
    .serData     (serData),
    .serClk      (serClk),
    .busy        (busy),
    .underrun    (underrun),
    .frameCnt    (frameCnt),
    .underrunCnt (underrunCnt)
  );

  always #5 masterClk = ~masterClk;

  always @(posedge masterClk) cyc <= cyc + 1;

  initial begin
    logic pc;
    logic dr;
    int   hs;
    pc = 1'b0;
    dr = 1'b0;
    hs = 0;
    forever begin
      @(negedge masterClk);
      if (serClk === 1'b1 && !pc) begin
        riseT.push_back(cyc);
        bits.push_back(serData);
        dr = serData;
        hs = cyc;
      end else if (serClk === 1'b1 && serData !== dr) begin
        glitches++;
      end
      if (serClk !== 1'b1 && pc) hiW.push_back(cyc - hs);
      pc = (serClk === 1'b1);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic clear_cap();
    riseT.delete();
    bits.delete();
    hiW.delete();
    expBits.delete();
    gapBefore.delete();
    glitches = 0;
  endtask

  task automatic model_pix(input logic [23:0] d, input bit gap);
    for (int b = 23; b >= 0; b--) begin
      expBits.push_back(d[b]);
      gapBefore.push_back(gap && (b == 23));
    end
  endtask

  task automatic send(input string nm, input logic [23:0] d,
                      input logic l, output int oc, output int xc);
    int n;
    n = 0;
    @(negedge masterClk);
    while (pixReady !== 1'b1 && n < 5000) begin
      @(negedge masterClk);
      n++;
    end
    oc = cyc;
    xc = -1;
    if (pixReady !== 1'b1) begin
      chk({nm, "_ready_timeout"}, pixReady, 1);
    end else begin
      pixData  = d;
      pixLast  = l;
      pixValid = 1'b1;
      @(posedge masterClk);
      #1;
      xc = cyc;
      pixValid = 1'b0;
      pixLast  = 1'b0;
      chk({nm, "_rdy_drop"}, pixReady, 0);
      chk({nm, "_ur_clear"}, underrun, 0);
    end
  endtask

  task automatic wait_bits(input string nm, input int n);
    int k;
    k = 0;
    while (bits.size() < n && k < n * BIT_CYC + 6000) begin
      @(negedge masterClk);
      k++;
    end
    chk({nm, "_nbits_seen"}, bits.size(), n);
  endtask

  task automatic wait_idle(input string nm, output int t);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 6000) begin
      @(negedge masterClk);
      k++;
    end
    t = cyc;
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic check_stream(input string nm);
    int bad;
    int d;
    chk({nm, "_nbits"}, bits.size(), expBits.size());
    bad = 0;
    for (int i = 0; i < bits.size() && i < expBits.size(); i++)
      if (bits[i] != expBits[i]) bad++;
    chk({nm, "_bits"}, bad, 0);
    bad = 0;
    for (int i = 1; i < riseT.size(); i++) begin
      d = riseT[i] - riseT[i-1];
      if (i < gapBefore.size() && gapBefore[i]) begin
        if (d < GAP_MIN) bad++;
      end else if (d != BIT_CYC) begin
        bad++;
      end
    end
    chk({nm, "_slots"}, bad, 0);
    bad = 0;
    foreach (hiW[i]) if (hiW[i] != HALF) bad++;
    chk({nm, "_high"}, bad, 0);
    chk({nm, "_glitch"}, glitches, 0);
  endtask

  task automatic chk_stats(input string nm);
`ifdef WS2811_SER_STATS_EN
    chk({nm, "_frameCnt"}, frameCnt, mFrames & 16'hFFFF);
    chk({nm, "_urCnt"}, underrunCnt, (mUr > 255) ? 255 : mUr);
`else
    chk({nm, "_frameCnt"}, frameCnt, 0);
    chk({nm, "_urCnt"}, underrunCnt, 0);
`endif
  endtask

  initial begin
    int oc;
    int xc;
    int t;
    int relC;
    int latchEnt;
    int prevLast;
    int np;
    logic lst;
    logic [23:0] w;
    logic [23:0] d;
    logic [23:0] p3[3];

    tbl[0] = '{24'hA50000, 1'b1, 1'b0, 24'hA50000};
    tbl[1] = '{24'h0000FF, 1'b0, 1'b1, 24'h0000FF};
    tbl[2] = '{24'hFFFFFF, 1'b1, 1'b0, 24'hFFFFFF};
    tbl[3] = '{24'h123456, 1'b0, 1'b1, 24'h123456};

    rst      = 1'b1;
    pixData  = '0;
    pixValid = 1'b0;
    pixLast  = 1'b0;
    repeat (3) @(negedge masterClk);
    chk("rst_serData", serData, 0);
    chk("rst_serClk", serClk, 0);
    chk("rst_pixReady", pixReady, 0);
    chk("rst_busy", busy, 1);
    chk("rst_underrun", underrun, 0);
    chk("rst_frameCnt", frameCnt, 0);
    chk("rst_urCnt", underrunCnt, 0);
    rst  = 1'b0;
    relC = cyc;

    for (int i = 0; i < 4; i++) begin
      clear_cap();
      model_pix(tbl[i].data, 1'b0);
      send("vec", tbl[i].data, tbl[i].last, oc, xc);
      wait_bits("vec", 24);
      w = '0;
      if (bits.size() >= 24)
        for (int b = 0; b < 24; b++) w = {w[22:0], bits[b]};
      chk("vec_word", w, tbl[i].expWord);
      if (i == 0 && riseT.size() > 0)
        chk_rng("first_rise", riseT[0] - relC, LATCH_CYC, LATCH_CYC + 3);
      repeat (60) @(negedge masterClk);
      chk("vec_underrun", underrun, tbl[i].expUr);
      chk("vec_latch_busy", busy, 1);
      chk("vec_latch_clk", serClk, 0);
      check_stream("vec");
      wait_idle("vec", t);
      if (riseT.size() > 0)
        chk("vec_latch_len", t - riseT[riseT.size()-1], LATCH_LEN);
      if (tbl[i].last) mFrames++;
      else mUr++;
      chk_stats("vec");
    end

    clear_cap();
    p3[0] = 24'h00FF00;
    p3[1] = 24'h0F0F0F;
    p3[2] = 24'h800001;
    for (int i = 0; i < 3; i++) begin
      model_pix(p3[i], 1'b0);
      send("stream", p3[i], (i == 2), oc, xc);
    end
    wait_bits("stream", 72);
    repeat (60) @(negedge masterClk);
    chk("stream_underrun", underrun, 0);
    check_stream("stream");
    wait_idle("stream", t);
    mFrames++;
    chk_stats("stream");

    clear_cap();
    model_pix(24'hC3C3C3, 1'b0);
    send("latch", 24'hC3C3C3, 1'b1, oc, xc);
    wait_bits("latch", 24);
    latchEnt = (riseT.size() > 0) ? riseT[riseT.size()-1] + BIT_CYC - 1 : cyc;
    while (cyc < latchEnt + 500) @(negedge masterClk);
    chk("latch_busy", busy, 1);
    model_pix(24'h3C3C3C, 1'b1);
    send("latch", 24'h3C3C3C, 1'b1, oc, xc);
    chk("latch_accept", xc - oc, 1);
    wait_bits("latch", 48);
    if (riseT.size() > 24)
      chk("latch_first", riseT[24] - latchEnt, LATCH_CYC + 2);
    check_stream("latch");
    wait_idle("latch", t);
    mFrames += 2;
    chk_stats("latch");

    clear_cap();
    send("rstmid", 24'hFFFFFF, 1'b1, oc, xc);
    send("rstmid", 24'h00FF00, 1'b1, oc, xc);
    wait_bits("rstmid", 11);
    repeat (11) @(negedge masterClk);
    chk("rstmid_pre_clk", serClk, 1);
    chk("rstmid_pre_data", serData, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_async_clk", serClk, 0);
    chk("rstmid_async_data", serData, 0);
    chk("rstmid_busy", busy, 1);
    @(negedge masterClk);
    rst  = 1'b0;
    relC = cyc;
    clear_cap();
    mFrames = 0;
    mUr = 0;
    repeat (LATCH_CYC - 1) @(negedge masterClk);
    chk("rstmid_nostrobe", bits.size(), 0);
    chk("rstmid_gap_busy", busy, 1);
    repeat (2) @(negedge masterClk);
    chk("rstmid_hold_gone", busy, 0);
    chk("rstmid_ready", pixReady, 1);
    repeat (200) @(negedge masterClk);
    chk("rstmid_nostrobe2", bits.size(), 0);
    chk_stats("rstmid");

    prevLast = -1;
    for (int f = 0; f < 4; f++) begin
      clear_cap();
      np  = $urandom_range(1, 2);
      lst = 1'($urandom_range(0, 1));
      for (int p = 0; p < np; p++) begin
        d = 24'($urandom);
        model_pix(d, 1'b0);
        send("rnd", d, (p == np - 1) ? lst : 1'b0, oc, xc);
      end
      wait_bits("rnd", 24 * np);
      if (prevLast >= 0 && riseT.size() > 0)
        chk_rng("rnd_gap", riseT[0] - prevLast, GAP_MIN, 1000000);
      repeat (60) @(negedge masterClk);
      chk("rnd_underrun", underrun, !lst);
      check_stream("rnd");
      if (riseT.size() > 0) prevLast = riseT[riseT.size()-1];
      if (lst) mFrames++;
      else mUr++;
      chk_stats("rnd");
      repeat ($urandom_range(0, 2600)) @(negedge masterClk);
    end
    wait_idle("rnd", t);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
